// File: rtl/line_ptr_ctrl_pkg.sv
// Shared sizing and full/empty pointer compares for the line buffer, so the line RAM,
// the writer/reader FSMs and this controller all agree on geometry.
package line_ptr_ctrl_pkg;

    localparam int unsigned DefLineAw = 2;
    localparam int unsigned MaxLineAw = 8;
    localparam int unsigned PtrWMax   = MaxLineAw + 1;

    typedef enum logic [1:0] {
        OpNone = 2'b00,
        OpRd   = 2'b01,
        OpWr   = 2'b10,
        OpBoth = 2'b11
    } line_op_e;

    function automatic logic ptr_empty(input logic [PtrWMax-1:0] wr, input logic [PtrWMax-1:0] rd);
        return wr == rd;
    endfunction

    // Pointers are zero-extended, so only the wrap bit at position aw may differ when full.
    function automatic logic ptr_full(input logic [PtrWMax-1:0] wr, input logic [PtrWMax-1:0] rd,
                                      input int unsigned aw);
        return (wr ^ rd) == (PtrWMax'(1) << aw);
    endfunction

endpackage

// File: rtl/line_ptr_cnt.sv
// Wrapping line pointer: (LINE_AW+1)-bit counter whose MSB is the wrap bit.
module line_ptr_cnt #(
    parameter int unsigned LINE_AW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [LINE_AW:0] ptr
);

    localparam int unsigned PtrW = LINE_AW + 1;

    logic [LINE_AW:0] ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (en) begin
            ptr_q <= ptr_q + PtrW'(1);
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/line_ptr_ctrl.sv
// Line-pointer controller: accept logic, occupancy count, threshold flags and sticky
// overflow/underflow errors for a 2**LINE_AW-deep line buffer.
module line_ptr_ctrl
    import line_ptr_ctrl_pkg::*;
#(
    parameter int unsigned LINE_AW    = DefLineAw,
    parameter int unsigned AFULL_LVL  = 3,
    parameter int unsigned AEMPTY_LVL = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_line_incr,
    input  logic               rd_line_incr,
    input  logic               err_clr,
    output logic [LINE_AW-1:0] wr_line_ptr,
    output logic [LINE_AW-1:0] rd_line_ptr,
    output logic               wr_greenflag,
    output logic               rd_greenflag,
    output logic               wr_afull,
    output logic               rd_aempty,
    output logic [LINE_AW:0]   line_cnt,
    output logic               err_ovf,
    output logic               err_udf
);

    localparam int unsigned CntW = LINE_AW + 1;

    logic [LINE_AW:0] wr_ptr, rd_ptr;
    logic [LINE_AW:0] line_cnt_q, line_cnt_d;
    logic             full, empty;
    logic             wr_acc, rd_acc;
    logic             err_ovf_q, err_ovf_d;
    logic             err_udf_q, err_udf_d;
    line_op_e         op;

    assign full  = ptr_full(PtrWMax'(wr_ptr), PtrWMax'(rd_ptr), LINE_AW);
    assign empty = ptr_empty(PtrWMax'(wr_ptr), PtrWMax'(rd_ptr));

    assign wr_acc = wr_line_incr & ~full;
    assign rd_acc = rd_line_incr & ~empty;
    assign op     = line_op_e'({wr_acc, rd_acc});

    line_ptr_cnt #(
        .LINE_AW (LINE_AW)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (wr_acc),
        .ptr (wr_ptr)
    );

    line_ptr_cnt #(
        .LINE_AW (LINE_AW)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (rd_acc),
        .ptr (rd_ptr)
    );

    always_comb begin
        line_cnt_d = line_cnt_q;
        unique case (op)
            OpWr:    line_cnt_d = line_cnt_q + CntW'(1);
            OpRd:    line_cnt_d = line_cnt_q - CntW'(1);
            default: line_cnt_d = line_cnt_q;
        endcase
    end

    // A new offending request wins over a coincident clear.
    always_comb begin
        err_ovf_d = (wr_line_incr & full) | (err_ovf_q & ~err_clr);
        err_udf_d = (rd_line_incr & empty) | (err_udf_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_cnt_q <= '0;
            err_ovf_q  <= 1'b0;
            err_udf_q  <= 1'b0;
        end else begin
            line_cnt_q <= line_cnt_d;
            err_ovf_q  <= err_ovf_d;
            err_udf_q  <= err_udf_d;
        end
    end

    assign wr_line_ptr  = wr_ptr[LINE_AW-1:0];
    assign rd_line_ptr  = rd_ptr[LINE_AW-1:0];
    assign wr_greenflag = ~full;
    assign rd_greenflag = ~empty;
    assign wr_afull     = line_cnt_q >= CntW'(AFULL_LVL);
    assign rd_aempty    = line_cnt_q <= CntW'(AEMPTY_LVL);
    assign line_cnt     = line_cnt_q;
    assign err_ovf      = err_ovf_q;
    assign err_udf      = err_udf_q;

endmodule

// File: tb/tb_line_ptr_ctrl.sv
// Scoreboard bench for line_ptr_ctrl: depth-4 and depth-8 instances share one stimulus stream.
module tb_line_ptr_ctrl;

    typedef struct {
        int unsigned wp;
        int unsigned rp;
        int unsigned cnt;
        bit          wgf;
        bit          rgf;
        bit          af;
        bit          ae;
        bit          ovf;
        bit          udf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic wr_line_incr = 1'b0;
    logic rd_line_incr = 1'b0;
    logic err_clr = 1'b0;

    logic [1:0] a_wp, a_rp;
    logic [2:0] a_cnt;
    logic       a_wgf, a_rgf, a_af, a_ae, a_ovf, a_udf;
    logic [2:0] b_wp, b_rp;
    logic [3:0] b_cnt;
    logic       b_wgf, b_rgf, b_af, b_ae, b_ovf, b_udf;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    exp_t        exp_q[$];
    int unsigned m_wr[2], m_rd[2], m_cnt[2];
    bit          m_ovf[2], m_udf[2];
    int unsigned dep[2]  = '{4, 8};
    int unsigned afl[2]  = '{3, 6};
    int unsigned ael[2]  = '{1, 2};

    always #5 clk = ~clk;

    line_ptr_ctrl #(
        .LINE_AW    (2),
        .AFULL_LVL  (3),
        .AEMPTY_LVL (1)
    ) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .wr_line_incr (wr_line_incr),
        .rd_line_incr (rd_line_incr),
        .err_clr      (err_clr),
        .wr_line_ptr  (a_wp),
        .rd_line_ptr  (a_rp),
        .wr_greenflag (a_wgf),
        .rd_greenflag (a_rgf),
        .wr_afull     (a_af),
        .rd_aempty    (a_ae),
        .line_cnt     (a_cnt),
        .err_ovf      (a_ovf),
        .err_udf      (a_udf)
    );

    line_ptr_ctrl #(
        .LINE_AW    (3),
        .AFULL_LVL  (6),
        .AEMPTY_LVL (2)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .wr_line_incr (wr_line_incr),
        .rd_line_incr (rd_line_incr),
        .err_clr      (err_clr),
        .wr_line_ptr  (b_wp),
        .rd_line_ptr  (b_rp),
        .wr_greenflag (b_wgf),
        .rd_greenflag (b_rgf),
        .wr_afull     (b_af),
        .rd_aempty    (b_ae),
        .line_cnt     (b_cnt),
        .err_ovf      (b_ovf),
        .err_udf      (b_udf)
    );

    task automatic check_val(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Occupancy-based reference: full/empty come from the count, not from pointer compares.
    task automatic model_step(input int i, input bit w, input bit r, input bit c, input bit rs);
        bit   full, empty, wa, ra;
        exp_t e;
        if (rs) begin
            m_wr[i] = 0; m_rd[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
        end else begin
            full     = (m_cnt[i] == dep[i]);
            empty    = (m_cnt[i] == 0);
            wa       = w && !full;
            ra       = r && !empty;
            m_ovf[i] = (w && full) || (m_ovf[i] && !c);
            m_udf[i] = (r && empty) || (m_udf[i] && !c);
            if (wa) m_wr[i] = (m_wr[i] + 1) % (2 * dep[i]);
            if (ra) m_rd[i] = (m_rd[i] + 1) % (2 * dep[i]);
            m_cnt[i] = m_cnt[i] + wa - ra;
        end
        e.wp  = m_wr[i] % dep[i];
        e.rp  = m_rd[i] % dep[i];
        e.cnt = m_cnt[i];
        e.wgf = (m_cnt[i] != dep[i]);
        e.rgf = (m_cnt[i] != 0);
        e.af  = (m_cnt[i] >= afl[i]);
        e.ae  = (m_cnt[i] <= ael[i]);
        e.ovf = m_ovf[i];
        e.udf = m_udf[i];
        exp_q.push_back(e);
    endtask

    task automatic compare_inst(input int i);
        exp_t  e;
        string p;
        e = exp_q.pop_front();
        p = (i == 0) ? "d4" : "d8";
        if (i == 0) begin
            check_val({p, ".wr_ptr"}, a_wp, e.wp);
            check_val({p, ".rd_ptr"}, a_rp, e.rp);
            check_val({p, ".cnt"}, a_cnt, e.cnt);
            check_val({p, ".wr_green"}, a_wgf, e.wgf);
            check_val({p, ".rd_green"}, a_rgf, e.rgf);
            check_val({p, ".afull"}, a_af, e.af);
            check_val({p, ".aempty"}, a_ae, e.ae);
            check_val({p, ".err_ovf"}, a_ovf, e.ovf);
            check_val({p, ".err_udf"}, a_udf, e.udf);
        end else begin
            check_val({p, ".wr_ptr"}, b_wp, e.wp);
            check_val({p, ".rd_ptr"}, b_rp, e.rp);
            check_val({p, ".cnt"}, b_cnt, e.cnt);
            check_val({p, ".wr_green"}, b_wgf, e.wgf);
            check_val({p, ".rd_green"}, b_rgf, e.rgf);
            check_val({p, ".afull"}, b_af, e.af);
            check_val({p, ".aempty"}, b_ae, e.ae);
            check_val({p, ".err_ovf"}, b_ovf, e.ovf);
            check_val({p, ".err_udf"}, b_udf, e.udf);
        end
    endtask

    // Inputs stay applied while the post-edge state is checked, exposing any input-to-output path.
    task automatic cycle(input bit w, input bit r, input bit c, input bit rs);
        wr_line_incr = w;
        rd_line_incr = r;
        err_clr      = c;
        rst          = rs;
        model_step(0, w, r, c, rs);
        model_step(1, w, r, c, rs);
        @(posedge clk);
        #1;
        compare_inst(0);
        compare_inst(1);
    endtask

    initial begin
        // reset overrides a coincident write
        cycle(1, 0, 0, 1);
        // fill depth-4 instance; ovf on extra write
        repeat (4) cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        // drain, then simultaneous incr while empty
        repeat (4) cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 0, 1, 0);
        // refill to full, both incr at full, then both in mid-range
        repeat (3) cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        // set and clear together: set wins
        cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 0);
        cycle(0, 0, 1, 0);
        // drain past empty, clear
        repeat (9) cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 0);
        // write/read pairs across pointer wrap
        repeat (9) begin
            cycle(1, 0, 0, 0);
            cycle(0, 1, 0, 0);
        end
        // reset mid-operation with write high, on both depths
        repeat (3) cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 1);
        repeat (7) cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 1);
        // random traffic
        for (int k = 0; k < 300; k++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
        end
        check_val("sb_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
